// File: rtl/tm_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tm_mem_arbiter
// Shares the single synchronous port of the Turing machine tape/transition
// memory between the program/input loader (requester 0) and the tape-execution
// engine (requester 1). A requester may lock the port across several cycles
// for read-modify-write sequences. A bounded hold counter forces the lock
// open when the other requester has waited MAX_HOLD cycles.
//
// Optional feature macro: TM_ARB_ROUND_ROBIN_EN
//   defined   : IDLE ties go to the requester not granted most recently
//   undefined : requester 0 always wins IDLE ties
//
// Ports
//   clock, reset            system clock, asynchronous active-high reset
//   req/lock/we/addr/wdata  per-requester access request (0 = loader, 1 = engine)
//   gnt0/gnt1               combinational grant, access accepted this cycle
//   rvalid/rdata            read return, one cycle after a granted read
//   mem_re/mem_we/mem_addr/mem_wdata/mem_rdata   memory pins
//   owner                   locked owner (00 none, 01 req0, 10 req1)
//   lock_err                one-cycle pulse after a forced lock release
// -----------------------------------------------------------------------------
module tm_mem_arbiter #(
  parameter int DW       = 4,
  parameter int AW       = 6,
  parameter int MAX_HOLD = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner,
  output logic          lock_err
);

  localparam int            CW        = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);

  // State encoding doubles as the owner output encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_hold;
  logic          r_force0;
  logic          r_force1;
  logic          r_lock_err;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_timeout;
  logic          w_tie_to1;
  logic          w_other_req;
`ifdef TM_ARB_ROUND_ROBIN_EN
  logic          r_last;
`endif

  // Tie-break choice for IDLE: a pending force flag beats the priority rule.
  always_comb begin
`ifdef TM_ARB_ROUND_ROBIN_EN
    w_tie_to1 = ~r_last;
`else
    w_tie_to1 = 1'b0;
`endif
    if (r_force0) begin
      w_tie_to1 = 1'b0;
    end else if (r_force1) begin
      w_tie_to1 = 1'b1;
    end
  end

  // The requester that does not currently own the locked port.
  assign w_other_req = (r_state == ST_OWN0) ? req1 :
                       (r_state == ST_OWN1) ? req0 : 1'b0;

  // Next-state and raw grant logic.
  always_comb begin
    w_next    = r_state;
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0 && (!req1 || !w_tie_to1)) begin
          w_gnt0 = 1'b1;
          if (lock0) w_next = ST_OWN0;
        end else if (req1) begin
          w_gnt1 = 1'b1;
          if (lock1) w_next = ST_OWN1;
        end
      end
      ST_OWN0: begin
        w_gnt0 = req0;
        // A lock drop on the timeout cycle is an ordinary release.
        if (!lock0) begin
          w_next = ST_IDLE;
        end else if (w_other_req && (r_hold == HOLD_LAST)) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_OWN1: begin
        w_gnt1 = req1;
        if (!lock1) begin
          w_next = ST_IDLE;
        end else if (w_other_req && (r_hold == HOLD_LAST)) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Nothing is granted while reset is asserted.
  assign gnt0 = w_gnt0 & ~reset;
  assign gnt1 = w_gnt1 & ~reset;

  assign mem_re    = (gnt0 & ~we0) | (gnt1 & ~we1);
  assign mem_we    = (gnt0 & we0) | (gnt1 & we1);
  assign mem_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : {AW{1'b0}});
  assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : {DW{1'b0}});

  // FSM state, hold counter, force flags and error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hold     <= {CW{1'b0}};
      r_force0   <= 1'b0;
      r_force1   <= 1'b0;
      r_lock_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_lock_err <= w_timeout;
      if (r_state == ST_IDLE) begin
        r_hold <= {CW{1'b0}};
      end else if (w_other_req && (r_hold != HOLD_MAX)) begin
        r_hold <= r_hold + {{(CW-1){1'b0}}, 1'b1};
      end
      // Force flags live for exactly one IDLE cycle after a timeout.
      if (r_state == ST_IDLE) begin
        r_force0 <= 1'b0;
        r_force1 <= 1'b0;
      end else if (w_timeout) begin
        r_force0 <= (r_state == ST_OWN1);
        r_force1 <= (r_state == ST_OWN0);
      end
    end
  end

`ifdef TM_ARB_ROUND_ROBIN_EN
  // Most recent IDLE winner; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if ((r_state == ST_IDLE) && (gnt0 || gnt1)) begin
      r_last <= gnt1;
    end
  end
`endif

  // Read return tracking; rdata latches the returned word for holding.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= {DW{1'b0}};
      r_rdata1  <= {DW{1'b0}};
    end else begin
      r_rvalid0 <= gnt0 & ~we0;
      r_rvalid1 <= gnt1 & ~we1;
      if (r_rvalid0) r_rdata0 <= mem_rdata;
      if (r_rvalid1) r_rdata1 <= mem_rdata;
    end
  end

  // The memory word arrives in the rvalid cycle itself, so it is forwarded
  // then and the latched copy is shown on every other cycle.
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;
  assign rdata0   = r_rvalid0 ? mem_rdata : r_rdata0;
  assign rdata1   = r_rvalid1 ? mem_rdata : r_rdata1;
  assign owner    = r_state;
  assign lock_err = r_lock_err;

endmodule

// File: tb/tb_tm_mem_arbiter.sv
module tb_tm_mem_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1, lock0, lock1, we0, we1;
  logic [5:0] addr0, addr1;
  logic [3:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [3:0] rdata0, rdata1;
  logic       mem_re, mem_we;
  logic [5:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata = 4'h0;
  logic [1:0] owner;
  logic       lock_err;

  logic [3:0] mem [0:63];

  int n_checks = 0;
  int n_fail   = 0;

  tm_mem_arbiter #(.DW(4), .AW(6), .MAX_HOLD(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .lock_err(lock_err)
  );

  always #5 clock = ~clock;

  // Synchronous single-port memory model.
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; addr0 = 6'd0; addr1 = 6'd0;
    wdata0 = 4'h0; wdata1 = 4'h0;
  endtask

  // Advance one clock; inputs are applied 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 4'h0;
    mem[5] = 4'hA;
    mem[3] = 4'h6;
    clear_inputs();
    reset = 1'b1;
    step();
    // Requests during reset must not be granted.
    req0 = 1'b1; addr0 = 6'd5;
    settle();
    check_eq("rst_gnt0", gnt0, 1'b0);
    check_eq("rst_gnt1", gnt1, 1'b0);
    check_eq("rst_mem_re", mem_re, 1'b0);
    check_eq("rst_owner", owner, 2'b00);
    check_eq("rst_rvalid0", rvalid0, 1'b0);
    check_eq("rst_rdata0", rdata0, 4'h0);
    check_eq("rst_lock_err", lock_err, 1'b0);
    reset = 1'b0;
    step();

    // Simple read of address 5 by requester 0.
    clear_inputs(); req0 = 1'b1; addr0 = 6'd5;
    settle();
    check_eq("rd_gnt0", gnt0, 1'b1);
    check_eq("rd_gnt1", gnt1, 1'b0);
    check_eq("rd_mem_re", mem_re, 1'b1);
    check_eq("rd_mem_we", mem_we, 1'b0);
    check_eq("rd_mem_addr", mem_addr, 6'd5);
    check_eq("rd_owner", owner, 2'b00);
    step();
    clear_inputs();
    // Same cycle: requester 1 writes 7 to address 12 without lock.
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd12; wdata1 = 4'h7;
    settle();
    check_eq("rd_rvalid0", rvalid0, 1'b1);
    check_eq("rd_rdata0", rdata0, 4'hA);
    check_eq("rd_rvalid1", rvalid1, 1'b0);
    check_eq("wr_gnt1", gnt1, 1'b1);
    check_eq("wr_mem_we", mem_we, 1'b1);
    check_eq("wr_mem_re", mem_re, 1'b0);
    check_eq("wr_mem_wdata", mem_wdata, 4'h7);
    step();
    clear_inputs();
    settle();
    check_eq("wr_no_rvalid1", rvalid1, 1'b0);
    check_eq("hold_rdata0", rdata0, 4'hA);
    check_eq("hold_rvalid0", rvalid0, 1'b0);
    check_eq("idle_mem_addr", mem_addr, 6'd0);
    step();

    // Tie without lock for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      clear_inputs(); req0 = 1'b1; req1 = 1'b1; addr0 = 6'd1; addr1 = 6'd2;
      settle();
`ifdef TM_ARB_ROUND_ROBIN_EN
      check_eq("tie_gnt0", gnt0, (i % 2 == 0) ? 1'b1 : 1'b0);
      check_eq("tie_gnt1", gnt1, (i % 2 == 0) ? 1'b0 : 1'b1);
      check_eq("tie_mem_addr", mem_addr, (i % 2 == 0) ? 6'd1 : 6'd2);
`else
      check_eq("tie_gnt0", gnt0, 1'b1);
      check_eq("tie_gnt1", gnt1, 1'b0);
      check_eq("tie_mem_addr", mem_addr, 6'd1);
`endif
      step();
    end
    clear_inputs();
    step();

    // Locked read then unlocked write of 9 to address 12 while req0 waits.
    req1 = 1'b1; lock1 = 1'b1; addr1 = 6'd3;
    settle();
    check_eq("lk_gnt1_a", gnt1, 1'b1);
    check_eq("lk_owner_a", owner, 2'b00);
    step();
    req0 = 1'b1; addr0 = 6'd5;
    lock1 = 1'b0; we1 = 1'b1; addr1 = 6'd12; wdata1 = 4'h9;
    settle();
    check_eq("lk_owner_b", owner, 2'b10);
    check_eq("lk_gnt1_b", gnt1, 1'b1);
    check_eq("lk_gnt0_b", gnt0, 1'b0);
    check_eq("lk_mem_we_b", mem_we, 1'b1);
    check_eq("lk_mem_addr_b", mem_addr, 6'd12);
    check_eq("lk_rvalid1_b", rvalid1, 1'b1);
    check_eq("lk_rdata1_b", rdata1, 4'h6);
    step();
    req1 = 1'b0; lock1 = 1'b0; we1 = 1'b0;
    addr0 = 6'd12;
    settle();
    check_eq("lk_owner_c", owner, 2'b00);
    check_eq("lk_gnt0_c", gnt0, 1'b1);
    step();
    clear_inputs();
    settle();
    check_eq("lk_rvalid0_d", rvalid0, 1'b1);
    check_eq("lk_rdata0_d", rdata0, 4'h9);
    step();

    // Starvation timeout: req1 keeps lock1 while req0 waits.
    req1 = 1'b1; lock1 = 1'b1; addr1 = 6'd3;
    settle();
    check_eq("to_gnt1_idle", gnt1, 1'b1);
    step();
    req0 = 1'b1; addr0 = 6'd5;
    for (int k = 0; k < 8; k++) begin
      settle();
      check_eq("to_owner", owner, 2'b10);
      check_eq("to_gnt1", gnt1, 1'b1);
      check_eq("to_gnt0", gnt0, 1'b0);
      check_eq("to_lock_err_low", lock_err, 1'b0);
      step();
    end
    settle();
    check_eq("to_owner_rel", owner, 2'b00);
    check_eq("to_gnt0_forced", gnt0, 1'b1);
    check_eq("to_gnt1_rel", gnt1, 1'b0);
    check_eq("to_lock_err_pulse", lock_err, 1'b1);
    step();
    clear_inputs();
    settle();
    check_eq("to_lock_err_single", lock_err, 1'b0);
    step();

    // Lock dropped on the very cycle the hold counter reaches MAX_HOLD-1.
    req1 = 1'b1; lock1 = 1'b1; addr1 = 6'd3;
    step();
    req0 = 1'b1; addr0 = 6'd5;
    for (int k = 0; k < 7; k++) begin
      settle();
      check_eq("sd_owner", owner, 2'b10);
      step();
    end
    lock1 = 1'b0;
    settle();
    check_eq("sd_gnt1_last", gnt1, 1'b1);
    step();
    req1 = 1'b0;
    settle();
    check_eq("sd_owner_idle", owner, 2'b00);
    check_eq("sd_lock_err", lock_err, 1'b0);
    check_eq("sd_gnt0", gnt0, 1'b1);
    step();
    clear_inputs();
    settle();
    check_eq("sd_lock_err_2", lock_err, 1'b0);
    step();

    // Reset asserted the cycle after a granted read.
    req0 = 1'b1; addr0 = 6'd5;
    settle();
    check_eq("rr_gnt0", gnt0, 1'b1);
    step();
    reset = 1'b1;
    settle();
    check_eq("rr_rvalid0", rvalid0, 1'b0);
    check_eq("rr_owner", owner, 2'b00);
    check_eq("rr_mem_re", mem_re, 1'b0);
    check_eq("rr_gnt0", gnt0, 1'b0);
    step();
    settle();
    check_eq("rr_rvalid0_2", rvalid0, 1'b0);
    check_eq("rr_mem_re_2", mem_re, 1'b0);
    reset = 1'b0;
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tm_mem_arbiter.md
# tm_mem_arbiter

Two-requester arbiter for the single-port synchronous tape/transition memory of the Turing machine. It shares the one memory port between the program/input loader (requester 0) and the tape-execution engine (requester 1). It supports locked multi-cycle ownership for read-modify-write sequences and bounds how long a lock may starve the other requester. It sits between both requesters and the memory's re/we/addr/data pins.

## Interface
- DW, 4, memory word width
- AW, 6, memory address width
- MAX_HOLD, 8, max consecutive locked cycles while the other requester waits (≥2)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req0/req1  in  1  access request, held until granted
- lock0/lock1  in  1  keep ownership after this grant (valid with req)
- we0/we1  in  1  1 = write, 0 = read
- addr0/addr1  in  AW  access address
- wdata0/wdata1  in  DW  write data
- gnt0/gnt1  out  1  combinational; access accepted this cycle
- rvalid0/rvalid1  out  1  read data valid (one cycle after a granted read)
- rdata0/rdata1  out  DW  registered read data
- mem_re, mem_we  out  1  memory strobes
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_re
- owner  out  2  locked owner: 00 none, 01 req0, 10 req1
- lock_err  out  1  one-cycle pulse after a forced lock release

## Operation
- States: IDLE, OWN0, OWN1.
- IDLE: a single request wins. On a tie, priority decides (see Configuration). A pending force flag overrides priority for the flagged requester. The winner gets gnt the same cycle. If its lock is high, the next state is OWNx; otherwise the FSM stays in IDLE.
- OWNx: gntx = reqx. The other requester is never granted.
  - lockx low (with or without reqx): this cycle's access proceeds and the next state is IDLE.
- Hold counter: cleared in IDLE. In OWNx it increments each cycle the other requester's req is high.
  - When the counter equals MAX_HOLD-1 and the other req is high, the owner's access still completes this cycle.
  - Next state is IDLE, the force flag is set for the other requester, and lock_err pulses in the next cycle.
- Force flag: cleared after any IDLE cycle.
- Simultaneous lock drop and timeout: treated as a normal release. No force flag is set and lock_err does not pulse.
- Memory drive:
  - mem_re = granted & ~we.
  - mem_we = granted & we.
  - mem_addr and mem_wdata are muxed from the granted requester, and are zero when nothing is granted.
- Read return: the requester of a granted read sees rvalid high in the next cycle, with rdata = mem_rdata. Writes produce no rvalid. rdata holds its value when rvalid is low.
- owner = registered state encoding. It is 00 in IDLE even on a cycle where a grant is issued.

## Timing
- Reset values: state IDLE; owner 00; gnt0/gnt1 0; rvalid0/rvalid1 0; rdata0/rdata1 0; lock_err 0; hold counter 0; force flag clear.
- The round-robin pointer resets to "last = 1", so requester 0 wins the first tie.
- Grant latency is 0 cycles (combinational from req and state). Read latency is 1 cycle. Throughput is one access per cycle.
- Reset asserted mid-operation drops any in-flight rvalid. No access is granted while reset is high.
- Hold counter width is $clog2(MAX_HOLD+1). It saturates, never wraps.

## Configuration
- TM_ARB_ROUND_ROBIN_EN defined: IDLE ties go to the requester not granted most recently. The pointer updates on every IDLE grant.
- TM_ARB_ROUND_ROBIN_EN undefined: requester 0 always wins IDLE ties. The force flag and starvation limit still apply.

## Test plan
- Reset, then req0 read addr 5 (mem holds 4'hA) → gnt0 same cycle, mem_re=1, mem_addr=5; next cycle rvalid0=1, rdata0=4'hA, rvalid1=0.
- req0 and req1 both high in IDLE, no lock, 4 cycles:
  - with TM_ARB_ROUND_ROBIN_EN → grants alternate 0,1,0,1.
  - without TM_ARB_ROUND_ROBIN_EN → gnt0 on all 4 cycles.
- req1+lock1 read, then write addr 12 with lock1 low while req0 is held → owner=10 during the lock; gnt0=0 until the cycle after lock1 drops; gnt0 is then issued and owner returns to 00.
- req1 holds lock1 indefinitely while req0 waits, MAX_HOLD=8 → 8 owner grants, then IDLE, gnt0 next cycle, lock_err single pulse.
- lock1 drops on the same cycle the counter hits MAX_HOLD-1 → IDLE next cycle, lock_err stays 0.
- Assert reset the cycle after a granted read → rvalid stays 0, owner=00, mem_re=0 while reset is high.
